// File: rtl/ram_port_arbiter_d1.sv
// Round-robin arbiter for two requesters sharing one synchronous-read RAM port,
// with an optional zero-fill of every RAM word after reset.
module ram_port_arbiter_d1 #(
    parameter int AWIDTH         = 3,
    parameter int DWIDTH         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] rdata,
    output logic              init_done,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] CLR_LAST = AWIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic              last_gnt_q, last_gnt_d;   // 0 = A won last, 1 = B won last
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic              init_done_q, init_done_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
            clr_cnt_q   <= '0;
            last_gnt_q  <= 1'b1;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            init_done_q <= (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            last_gnt_q  <= last_gnt_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        last_gnt_d  = last_gnt_q;
        init_done_d = init_done_q;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;

        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d     = ST_ARB;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                // On conflict the requester that did not win last time gets the port.
                if (a_req && (!b_req || last_gnt_q)) begin
                    a_gnt = 1'b1;
                end else if (b_req) begin
                    b_gnt = 1'b1;
                end

                if (a_gnt) begin
                    ram_we     = a_we;
                    ram_addr   = a_addr;
                    ram_din    = a_wdata;
                    last_gnt_d = 1'b0;
                    a_rvalid_d = ~a_we;
                end else if (b_gnt) begin
                    ram_we     = b_we;
                    ram_addr   = b_addr;
                    ram_din    = b_wdata;
                    last_gnt_d = 1'b1;
                    b_rvalid_d = ~b_we;
                end
            end
        endcase
    end

    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign init_done = init_done_q;
    assign rdata     = ram_dout;

endmodule
